// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte handshake bundle for uart_tx_scheduler: per-requester valid,
// packed byte lanes (requester i in bits [8i+7:8i]) and the one-hot accept pulse.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one LSB-first UART tx line among NUM_REQ requesters, paced by txclk_en.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1 instead of 8N1).
module uart_tx_scheduler #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk_50mhz,
    input  logic                rst_n,
    input  logic                txclk_en,
    uart_tx_scheduler_if.slave  req_bus,
    output logic                tx,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                frame_done
);

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic [ID_W-1:0]     last, last_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic                tx_nxt;
    logic                busy_nxt;
    logic [NUM_REQ-1:0]  ready_nxt;
    logic [ID_W-1:0]     grant_nxt;
    logic                done_nxt;
    logic                any_vld;
    logic [ID_W-1:0]     win_idx;
    logic                accept;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    // Nearest valid index after the last grant wins; the scan runs far-to-near so the nearest overwrites.
    always_comb begin
        int idx;
        any_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req_bus.req_valid[idx]) begin
                any_vld = 1'b1;
                win_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        shreg_nxt = shreg;
        tx_nxt    = tx;
        busy_nxt  = busy;
        ready_nxt = '0;
        grant_nxt = grant_id;
        done_nxt  = 1'b0;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                if (any_vld) begin
                    accept    = 1'b1;
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                if (txclk_en) begin
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (txclk_en) begin
                    tx_nxt    = shreg[0];
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (txclk_en) begin
                    if (cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_nxt    = even_parity(shreg);
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        tx_nxt  = shreg[cnt + 3'd1];
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (txclk_en) begin
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // A pending request starts its start bit right at the end of this stop bit.
                if (txclk_en) begin
                    done_nxt = 1'b1;
                    if (any_vld) begin
                        accept    = 1'b1;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            ready_nxt[win_idx] = 1'b1;
            shreg_nxt          = req_bus.req_data[DATA_W*win_idx +: DATA_W];
            grant_nxt          = win_idx;
            last_nxt           = win_idx;
            busy_nxt           = 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            last              <= ID_W'(NUM_REQ - 1);
            tx                <= 1'b1;
            busy              <= 1'b0;
            req_bus.req_ready <= '0;
            grant_id          <= '0;
            frame_done        <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            last              <= last_nxt;
            tx                <= tx_nxt;
            busy              <= busy_nxt;
            req_bus.req_ready <= ready_nxt;
            grant_id          <= grant_nxt;
            frame_done        <= done_nxt;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        shreg <= shreg_nxt;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized scoreboard bench for uart_tx_scheduler: a round-robin reference model queues
// expected frames; an independent strobe-rate line decoder pops and compares them.
module tb_uart_tx_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      data;
        logic            b2b;
    } exp_t;

    logic            clk_50mhz = 1'b0;
    logic            rst_n;
    logic            txclk_en;
    logic            tx;
    logic            busy;
    logic [ID_W-1:0] grant_id;
    logic            frame_done;

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) req_bus ();

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .txclk_en   (txclk_en),
        .req_bus    (req_bus),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int checks = 0;
    int errors = 0;

    exp_t              exp_q[$];
    int                model_last = NUM_REQ - 1;
    logic [7:0]        rq_mem [NUM_REQ][16];
    int                rq_head [NUM_REQ];
    int                rq_len  [NUM_REQ];
    int                strobe_period = 4;
    int                strobe_cnt    = 0;
    logic              strobe_now    = 1'b0;
    logic [NUM_REQ-1:0] hs_mask;
    int                n_issued  = 0;
    int                n_aborted = 0;
    int                n_frames  = 0;
    int                n_done    = 0;
    int                n_ready   = 0;

    logic              en_q  = 1'b0;
    logic              rst_q = 1'b0;
    logic [NUM_REQ-1:0] vld_q = '0;

    always @(posedge clk_50mhz) begin
        en_q  <= txclk_en;
        rst_q <= rst_n;
        vld_q <= req_bus.req_valid;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic present(input int i);
        if (rq_head[i] < rq_len[i]) begin
            req_bus.req_valid[i]      = 1'b1;
            req_bus.req_data[8*i +: 8] = rq_mem[i][rq_head[i]];
        end else begin
            req_bus.req_valid[i] = 1'b0;
        end
    endtask

    // One clock: requesters react to accepted handshakes, then the baud strobe is driven.
    task automatic tick();
        @(negedge clk_50mhz);
        hs_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_bus.req_ready[i] && req_bus.req_valid[i]) begin
                hs_mask[i] = 1'b1;
                rq_head[i]++;
                present(i);
            end
        end
        if (strobe_cnt >= strobe_period - 1) begin
            strobe_cnt = 0;
            strobe_now = 1'b1;
        end else begin
            strobe_cnt++;
            strobe_now = 1'b0;
        end
        txclk_en = strobe_now;
    endtask

    task automatic load(input int i, input int n);
        rq_head[i] = 0;
        rq_len[i]  = n;
        for (int j = 0; j < n; j++) rq_mem[i][j] = 8'($urandom);
    endtask

    // Reference model: a rotating pointer visits requesters in order, serving one byte per visit.
    task automatic commit();
        int   rem [NUM_REQ];
        int   total;
        bit   first;
        exp_t e;
        total = 0;
        first = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = rq_len[i] - rq_head[i];
            total += rem[i];
        end
        while (total > 0) begin
            model_last = (model_last + 1) % NUM_REQ;
            if (rem[model_last] > 0) begin
                e.id   = ID_W'(model_last);
                e.data = rq_mem[model_last][rq_len[model_last] - rem[model_last]];
                e.b2b  = !first;
                exp_q.push_back(e);
                rem[model_last]--;
                total--;
                first = 1'b0;
                n_issued++;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) present(i);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy || (|req_bus.req_valid)) && c < budget) begin
            tick();
            c++;
        end
        repeat (3) tick();
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL drain_timeout: waited %0d cycles, pending=%0d busy=%b", c, exp_q.size(), busy);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Line decoder: samples tx once per bit period, right after each strobe takes effect.
    initial begin
        int         ph;
        int         gap;
        bit         pend_end;
        logic [7:0] sh;
        exp_t       cur;
        ph = 0; gap = 1; pend_end = 1'b0; sh = '0; cur = '0;
        forever begin
            @(negedge clk_50mhz);
            if (!rst_q) begin
                ph = 0; gap = 1; pend_end = 1'b0;
                continue;
            end
            if (frame_done === 1'b1) n_done++;
            if (req_bus.req_ready !== '0) begin
                n_ready++;
                checks++;
                if (!$onehot(req_bus.req_ready) || (req_bus.req_ready & ~vld_q) != '0) begin
                    errors++;
                    $display("FAIL ready_pulse: ready=%b valid=%b", req_bus.req_ready, vld_q);
                end
            end
            if (en_q) begin
                if (pend_end) begin
                    pend_end = 1'b0;
                    checks++;
                    if (frame_done !== 1'b1 || busy !== ~tx) begin
                        errors++;
                        $display("FAIL frame_end: frame_done=%b busy=%b tx=%b", frame_done, busy, tx);
                    end
                end
                if (ph == 0) begin
                    if (tx === 1'b0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            cur = '0;
                            $display("FAIL unexpected_frame: start bit with nothing expected");
                        end else begin
                            cur = exp_q.pop_front();
                            if (grant_id !== cur.id || busy !== 1'b1 || (cur.b2b && gap != 0) || (!cur.b2b && gap == 0)) begin
                                errors++;
                                $display("FAIL grant: grant_id=%0d busy=%b gap=%0d expected id=%0d b2b=%b",
                                         grant_id, busy, gap, cur.id, cur.b2b);
                            end
                        end
                        ph = 1;
                        sh = '0;
                    end else if (gap < 1000) begin
                        gap++;
                    end
                end else if (ph <= 8) begin
                    sh[ph-1] = tx;
                    ph++;
`ifndef UART_TX_PARITY_EN
                    if (ph == 9) ph = 10;
`endif
                end else if (ph == 9) begin
                    checks++;
                    if (tx !== ^sh) begin
                        errors++;
                        $display("FAIL parity: got %b expected %b", tx, ^sh);
                    end
                    ph = 10;
                end else begin
                    checks++;
                    if (tx !== 1'b1 || sh !== cur.data) begin
                        errors++;
                        $display("FAIL frame_data: byte %02h stop %b expected %02h stop 1", sh, tx, cur.data);
                    end
                    n_frames++;
                    pend_end = 1'b1;
                    gap = 0;
                    ph = 0;
                end
            end
        end
    end

    initial begin
        int c;
        int s;
        int cnt4;
        rst_n    = 1'b0;
        txclk_en = 1'b0;
        req_bus.req_valid = '0;
        req_bus.req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_head[i] = 0;
            rq_len[i]  = 0;
        end

        // Reset held with every requester valid; then round-robin 0,1,2,3,0 back-to-back.
        load(0, 2); load(1, 1); load(2, 1); load(3, 1);
        rq_mem[0][0] = 8'h11; rq_mem[1][0] = 8'h22; rq_mem[2][0] = 8'h33;
        rq_mem[3][0] = 8'h44; rq_mem[0][1] = 8'h55;
        commit();
        repeat (3) begin
            tick();
            chk("reset_tx", 32'(tx), 32'd1);
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_ready", 32'(req_bus.req_ready), 32'd0);
            chk("reset_done", 32'(frame_done), 32'd0);
            chk("reset_grant", 32'(grant_id), 32'd0);
        end
        rst_n = 1'b1;
        drain(4000);

        // Single frame 8'hA5 from req0.
        load(0, 1); rq_mem[0][0] = 8'hA5; commit();
        drain(1000);

        // Fairness skip: last grant 1, then requesters 0 and 3 only.
        load(1, 1); commit(); drain(1000);
        load(0, 1); load(3, 1); commit(); drain(2000);

        // Strobe coincident with the accept cycle must not start the frame.
        strobe_period = 4;
        tick();
        load(2, 1); commit();
        txclk_en = 1'b1; strobe_cnt = 0;
        c = 0;
        do begin
            tick();
            chk("align_hold", 32'(tx), 32'd1);
            c++;
        end while (!strobe_now && c < 10);
        tick();
        chk("align_start", 32'(tx), 32'd0);
        drain(1000);

        // Reset during data bit 4 (a 0 bit), then a clean frame from req2.
        load(1, 1); rq_mem[1][0] = 8'h0F; commit();
        c = 0;
        hs_mask = '0;
        while (!hs_mask[1] && c < 100) begin tick(); c++; end
        chk("abort_handshake", 32'(hs_mask[1]), 32'd1);
        s = strobe_now ? 1 : 0;
        while (s < 6 && c < 300) begin tick(); if (strobe_now) s++; c++; end
        tick();
        chk("abort_pre_tx", 32'(tx), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        n_aborted++;
        model_last = NUM_REQ - 1;
        load(2, 1); commit(); drain(1000);

        // Randomized batches at varying strobe rates.
        for (int b = 0; b < 14; b++) begin
            strobe_period = $urandom_range(2, 5);
            cnt4 = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                load(i, $urandom_range(0, 3));
                cnt4 += rq_len[i];
            end
            if (cnt4 == 0) load(NUM_REQ - 1, 1);
            commit();
            drain(8000);
        end

        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        chk("ready_pulses", 32'(n_ready), 32'(n_issued));
        chk("frames_seen", 32'(n_frames), 32'(n_issued - n_aborted));
        chk("frame_done_pulses", 32'(n_done), 32'(n_frames));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
